// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: control, strobe and handshake bundle between the sequencer and the RV32I datapath.
interface alu_sequencer_if;
    logic [31:0] Instruction;
    logic        zero;
    logic        InstrReady;
    logic        MemReady;
    logic        InstrReq;
    logic        IRWrite;
    logic        PCWrite;
    logic        PCSrc;
    logic        ALUOutWrite;
    logic [1:0]  ALUOp;
    logic        ALUSrc;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        MemRead;
    logic        MemWrite;
    logic        RegWrite;
    logic        MemtoReg;
    logic        Fault;
    logic [2:0]  State;
    modport master (
        input  Instruction, zero, InstrReady, MemReady,
        output InstrReq, IRWrite, PCWrite, PCSrc, ALUOutWrite, ALUOp, ALUSrc,
               funct3, funct7, MemRead, MemWrite, RegWrite, MemtoReg, Fault, State
    );
    modport slave (
        output Instruction, zero, InstrReady, MemReady,
        input  InstrReq, IRWrite, PCWrite, PCSrc, ALUOutWrite, ALUOp, ALUSrc,
               funct3, funct7, MemRead, MemWrite, RegWrite, MemtoReg, Fault, State
    );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK control for an RV32I subset datapath,
// with sticky fault on illegal instructions or memory handshake timeout.
module alu_sequencer #(
    parameter int TIMEOUT = 15
) (
    input logic clk,
    input logic rst,
    alu_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEMORY    = 3'd3,
        WRITEBACK = 3'd4,
        FAULT     = 3'd7
    } state_t;

    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic [6:0]    opc, f7;
    logic [2:0]    f3;
    logic          is_r, is_i, is_ld, is_st, is_br, legal, alu, waiting, ready, expired;

    assign opc   = bus.Instruction[6:0];
    assign f3    = bus.Instruction[14:12];
    assign f7    = bus.Instruction[31:25];
    assign is_r  = opc == 7'b0110011;
    assign is_i  = opc == 7'b0010011;
    assign is_ld = opc == 7'b0000011;
    assign is_st = opc == 7'b0100011;
    assign is_br = opc == 7'b1100011;

    // SLT/SLTU are outside the supported ALU set for both R and I forms
    assign legal = is_r ? (f7 == 7'h00 && !(f3 inside {3'b010, 3'b011})) ||
                          (f7 == 7'h20 && (f3 inside {3'b000, 3'b101}))
                 : is_i ? (f3 == 3'b001 ? f7 == 7'h00
                         : f3 == 3'b101 ? (f7 == 7'h00 || f7 == 7'h20)
                         : !(f3 inside {3'b010, 3'b011}))
                 : (is_ld || is_st) ? f3 == 3'b010
                 : is_br ? f3 inside {3'b000, 3'b001, 3'b100, 3'b101}
                 : 1'b0;

    assign waiting = state == FETCH || state == MEMORY;
    assign ready   = state == FETCH ? bus.InstrReady : bus.MemReady;
    assign expired = TIMEOUT != 0 && waiting && !ready && cnt == CW'(TIMEOUT - 1);

    // ALU fields are decoded from the held IR, so they stay stable from EXECUTE through WRITEBACK
    assign alu        = state inside {EXECUTE, MEMORY, WRITEBACK};
    assign bus.ALUOp  = !alu ? 2'b00 : (is_r || is_i) ? 2'b10 : is_br ? 2'b01 : 2'b00;
    assign bus.ALUSrc = alu && (is_i || is_ld || is_st);
    assign bus.funct3 = alu && (is_r || is_i || is_br) ? f3 : 3'b000;
    assign bus.funct7 = alu && (is_r || (is_i && f3 inside {3'b001, 3'b101})) ? f7 : 7'h00;
    assign bus.Fault  = state == FAULT;
    assign bus.State  = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= state_n != state ? '0 : cnt + CW'(waiting && !ready);
        end
    end

    always_comb begin
        state_n         = state;
        bus.InstrReq    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.PCWrite     = 1'b0;
        bus.PCSrc       = 1'b0;
        bus.ALUOutWrite = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.MemtoReg    = 1'b0;
        case (state)
            FETCH: begin
                bus.InstrReq = 1'b1;
                bus.IRWrite  = bus.InstrReady;
                bus.PCWrite  = bus.InstrReady;
                state_n      = bus.InstrReady ? DECODE : expired ? FAULT : FETCH;
            end
            DECODE: state_n = legal ? EXECUTE : FAULT;
            EXECUTE: begin
                bus.ALUOutWrite = 1'b1;
                bus.PCSrc       = is_br;
                bus.PCWrite     = is_br && bus.zero;
                state_n         = (is_ld || is_st) ? MEMORY : is_br ? FETCH : WRITEBACK;
            end
            MEMORY: begin
                bus.MemRead  = is_ld;
                bus.MemWrite = is_st;
                state_n      = bus.MemReady ? (is_ld ? WRITEBACK : FETCH) : expired ? FAULT : MEMORY;
            end
            WRITEBACK: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = is_ld;
                state_n      = FETCH;
            end
            default: state_n = FAULT;
        endcase
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed instruction traces with queued per-cycle expectations checked by a negedge monitor.
module tb_alu_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  alu_sequencer_if bus();
  alu_sequencer #(.TIMEOUT(15)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [25:0] v;
    string       n;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  localparam logic [31:0] ADD  = 32'h002081B3;
  localparam logic [31:0] ADDI = 32'hFFF08093;
  localparam logic [31:0] SRAI = 32'h4010D093;
  localparam logic [31:0] LW   = 32'h0000A183;
  localparam logic [31:0] BEQ  = 32'h00208463;
  localparam logic [31:0] SW   = 32'h0020A023;
  localparam logic [31:0] ILL  = 32'h0000007F;
  function automatic logic [25:0] ev(input logic [2:0] st, input logic [4:0] fs, input logic aw,
                                     input logic [1:0] op, input logic src, input logic [2:0] f3,
                                     input logic [6:0] f7, input logic [3:0] m);
    return {st, fs, aw, op, src, f3, f7, m};
  endfunction
  task automatic step(input logic r, input logic [31:0] ins, input logic ir, input logic mr,
                      input logic z, input logic [25:0] e, input string n);
    @(posedge clk);
    #1;
    rst             = r;
    bus.Instruction = ins;
    bus.InstrReady  = ir;
    bus.MemReady    = mr;
    bus.zero        = z;
    q.push_back('{e, n});
  endtask
  always @(negedge clk) begin
    if (q.size() != 0) begin
      automatic exp_t e = q.pop_front();
      automatic logic [25:0] act = {bus.State, bus.Fault, bus.InstrReq, bus.IRWrite, bus.PCWrite,
                                    bus.PCSrc, bus.ALUOutWrite, bus.ALUOp, bus.ALUSrc, bus.funct3,
                                    bus.funct7, bus.MemRead, bus.MemWrite, bus.RegWrite, bus.MemtoReg};
      checks++;
      if (act !== e.v) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.n, act, e.v);
      end
    end
  end
  initial begin
    logic [25:0] fok, fwt, dec, flt;
    fok = ev(3'd0, 5'b01110, 1'b0, 2'b00, 1'b0, 3'd0, 7'h00, 4'b0000);
    fwt = ev(3'd0, 5'b01000, 1'b0, 2'b00, 1'b0, 3'd0, 7'h00, 4'b0000);
    dec = ev(3'd1, 5'b00000, 1'b0, 2'b00, 1'b0, 3'd0, 7'h00, 4'b0000);
    flt = ev(3'd7, 5'b10000, 1'b0, 2'b00, 1'b0, 3'd0, 7'h00, 4'b0000);
    bus.Instruction = 32'h0;
    bus.InstrReady  = 1'b0;
    bus.MemReady    = 1'b0;
    bus.zero        = 1'b0;
    step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, fwt, "reset_state");
    @(negedge clk);
    #1;
    checks++;
    if (bus.State !== 3'd0 || bus.Fault !== 1'b0 || bus.InstrReq !== 1'b1) begin
      errors++;
      $display("FAIL reset_direct: State=%0d Fault=%b InstrReq=%b", bus.State, bus.Fault, bus.InstrReq);
    end
    step(1'b0, ADD, 1'b1, 1'b0, 1'b0, fok, "add_fetch");
    step(1'b0, ADD, 1'b1, 1'b1, 1'b0, dec, "add_decode");
    step(1'b0, ADD, 1'b1, 1'b1, 1'b0, ev(3'd2, 5'b00000, 1'b1, 2'b10, 1'b0, 3'd0, 7'h00, 4'b0000), "add_exec");
    step(1'b0, ADD, 1'b1, 1'b1, 1'b0, ev(3'd4, 5'b00000, 1'b0, 2'b10, 1'b0, 3'd0, 7'h00, 4'b0010), "add_wb");
    step(1'b0, ADDI, 1'b1, 1'b0, 1'b0, fok, "addi_fetch");
    step(1'b0, ADDI, 1'b0, 1'b0, 1'b0, dec, "addi_decode");
    step(1'b0, ADDI, 1'b0, 1'b0, 1'b0, ev(3'd2, 5'b00000, 1'b1, 2'b10, 1'b1, 3'd0, 7'h00, 4'b0000), "addi_exec");
    step(1'b0, ADDI, 1'b0, 1'b0, 1'b0, ev(3'd4, 5'b00000, 1'b0, 2'b10, 1'b1, 3'd0, 7'h00, 4'b0010), "addi_wb");
    step(1'b0, SRAI, 1'b1, 1'b0, 1'b0, fok, "srai_fetch");
    step(1'b0, SRAI, 1'b0, 1'b0, 1'b0, dec, "srai_decode");
    step(1'b0, SRAI, 1'b0, 1'b0, 1'b0, ev(3'd2, 5'b00000, 1'b1, 2'b10, 1'b1, 3'd5, 7'h20, 4'b0000), "srai_exec");
    step(1'b0, SRAI, 1'b0, 1'b0, 1'b0, ev(3'd4, 5'b00000, 1'b0, 2'b10, 1'b1, 3'd5, 7'h20, 4'b0010), "srai_wb");
    step(1'b0, LW, 1'b1, 1'b0, 1'b0, fok, "lw_fetch");
    step(1'b0, LW, 1'b0, 1'b0, 1'b0, dec, "lw_decode");
    step(1'b0, LW, 1'b0, 1'b0, 1'b0, ev(3'd2, 5'b00000, 1'b1, 2'b00, 1'b1, 3'd0, 7'h00, 4'b0000), "lw_exec");
    for (int i = 0; i < 4; i++)
      step(1'b0, LW, 1'b0, i == 3, 1'b0, ev(3'd3, 5'b00000, 1'b0, 2'b00, 1'b1, 3'd0, 7'h00, 4'b1000), "lw_mem");
    step(1'b0, LW, 1'b0, 1'b0, 1'b0, ev(3'd4, 5'b00000, 1'b0, 2'b00, 1'b1, 3'd0, 7'h00, 4'b0011), "lw_wb");
    step(1'b0, BEQ, 1'b1, 1'b0, 1'b0, fok, "beq_t_fetch");
    step(1'b0, BEQ, 1'b0, 1'b0, 1'b0, dec, "beq_t_decode");
    step(1'b0, BEQ, 1'b0, 1'b0, 1'b1, ev(3'd2, 5'b00011, 1'b1, 2'b01, 1'b0, 3'd0, 7'h00, 4'b0000), "beq_taken_exec");
    step(1'b0, BEQ, 1'b1, 1'b0, 1'b0, fok, "beq_n_fetch");
    step(1'b0, BEQ, 1'b0, 1'b0, 1'b0, dec, "beq_n_decode");
    step(1'b0, BEQ, 1'b0, 1'b0, 1'b0, ev(3'd2, 5'b00001, 1'b1, 2'b01, 1'b0, 3'd0, 7'h00, 4'b0000), "beq_not_taken_exec");
    step(1'b0, SW, 1'b1, 1'b0, 1'b0, fok, "sw_fetch");
    step(1'b0, SW, 1'b0, 1'b0, 1'b0, dec, "sw_decode");
    step(1'b0, SW, 1'b0, 1'b1, 1'b0, ev(3'd2, 5'b00000, 1'b1, 2'b00, 1'b1, 3'd0, 7'h00, 4'b0000), "sw_exec");
    step(1'b0, SW, 1'b0, 1'b0, 1'b0, ev(3'd3, 5'b00000, 1'b0, 2'b00, 1'b1, 3'd0, 7'h00, 4'b0100), "sw_mem");
    step(1'b1, SW, 1'b0, 1'b0, 1'b0, fwt, "sw_async_reset");
    step(1'b0, SW, 1'b0, 1'b0, 1'b0, fwt, "post_reset_fetch");
    step(1'b0, ILL, 1'b1, 1'b0, 1'b0, fok, "ill_fetch");
    step(1'b0, ILL, 1'b1, 1'b1, 1'b1, dec, "ill_decode");
    for (int i = 0; i < 20; i++)
      step(1'b0, ILL, 1'b1, 1'b1, i[0], flt, "ill_fault_hold");
    step(1'b1, ADD, 1'b0, 1'b0, 1'b0, fwt, "reset_fault_clear");
    for (int i = 0; i < 15; i++)
      step(1'b0, ADD, 1'b0, 1'b0, 1'b0, fwt, "timeout_wait");
    step(1'b0, ADD, 1'b0, 1'b0, 1'b0, flt, "timeout_fault");
    @(negedge clk);
    #1;
    checks++;
    if (bus.State !== 3'd7 || bus.Fault !== 1'b1 || bus.InstrReq !== 1'b0 || bus.PCWrite !== 1'b0) begin
      errors++;
      $display("FAIL expired_direct: State=%0d Fault=%b InstrReq=%b", bus.State, bus.Fault, bus.InstrReq);
    end
    step(1'b0, ADD, 1'b1, 1'b1, 1'b0, flt, "timeout_fault_hold");
    step(1'b1, ADD, 1'b0, 1'b0, 1'b0, fwt, "reset_again");
    for (int i = 0; i < 14; i++)
      step(1'b0, ADD, 1'b0, 1'b0, 1'b0, fwt, "late_wait");
    step(1'b0, ADD, 1'b1, 1'b0, 1'b0, fok, "late_ready_accept");
    step(1'b0, ADD, 1'b0, 1'b0, 1'b0, dec, "late_decode");
    step(1'b0, ADD, 1'b0, 1'b0, 1'b0, ev(3'd2, 5'b00000, 1'b1, 2'b10, 1'b0, 3'd0, 7'h00, 4'b0000), "late_exec");
    step(1'b0, ADD, 1'b0, 1'b0, 1'b0, ev(3'd4, 5'b00000, 1'b0, 2'b10, 1'b0, 3'd0, 7'h00, 4'b0010), "late_wb");
    step(1'b0, ADD, 1'b0, 1'b0, 1'b0, fwt, "late_back_to_fetch");
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
